// File: rtl/seq_gen.sv
// One-hot channel sequencer: masked, up/down, free-run or single sweep.
// Optional break-before-make gap cycle: define SEQ_GEN_GAP_EN.
module seq_gen #(
  parameter  int CHANNELS = 8,
  parameter  int DWELL_W  = 8,
  localparam int IDX_W    = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                oneshot,
  input  logic                start,
  input  logic                dir,
  input  logic [DWELL_W-1:0]  dwell,
  input  logic [CHANNELS-1:0] mask,
  output logic [IDX_W-1:0]    tick,
  output logic [CHANNELS-1:0] sel,
  output logic                step,
  output logic                wrap,
  output logic                done,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN
`ifdef SEQ_GEN_GAP_EN
    , GAP
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    tick_q, tick_d;
  logic [CHANNELS-1:0] sel_q, sel_d;
  logic                step_q, step_d;
  logic                wrap_q, wrap_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic [DWELL_W-1:0]  cnt_q, cnt_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic [IDX_W-1:0]    nxt;
  logic                nxt_wrap;
`ifdef SEQ_GEN_GAP_EN
  logic [IDX_W-1:0]    nxt_q, nxt_d;
  logic                pwrap_q, pwrap_d;
`endif

  function automatic logic [CHANNELS-1:0] onehot(
    input logic [IDX_W-1:0] i
  );
    logic [CHANNELS-1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  // First enabled channel from the start end of the scan direction
  function automatic logic [IDX_W-1:0] first_ch(
    input logic [CHANNELS-1:0] m,
    input logic                d
  );
    logic [IDX_W-1:0] r;
    logic             hit;
    int               idx;
    r   = '0;
    hit = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = d ? CHANNELS - 1 - k : k;
      if (!hit && m[IDX_W'(idx)]) begin
        hit = 1'b1;
        r   = IDX_W'(idx);
      end
    end
    return r;
  endfunction

  // Next enabled channel after cur, modulo CHANNELS; may return cur itself
  function automatic logic [IDX_W-1:0] next_ch(
    input logic [CHANNELS-1:0] m,
    input logic [IDX_W-1:0]    cur,
    input logic                d
  );
    logic [IDX_W-1:0] r;
    logic             hit;
    int               idx;
    r   = cur;
    hit = 1'b0;
    for (int k = 1; k <= CHANNELS; k++) begin
      if (d) idx = (int'(cur) + CHANNELS - k) % CHANNELS;
      else   idx = (int'(cur) + k) % CHANNELS;
      if (!hit && m[IDX_W'(idx)]) begin
        hit = 1'b1;
        r   = IDX_W'(idx);
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    sel_d    = sel_q;
    step_d   = 1'b0;
    wrap_d   = 1'b0;
    done_d   = 1'b0;
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    dwell_d  = dwell_q;
`ifdef SEQ_GEN_GAP_EN
    nxt_d    = nxt_q;
    pwrap_d  = pwrap_q;
`endif
    nxt      = next_ch(mask, tick_q, dir);
    nxt_wrap = dir ? (nxt >= tick_q) : (nxt <= tick_q);
    unique case (state_q)
      IDLE: begin
        if (en && mask != '0 && (!oneshot || start)) begin
          state_d = RUN;
          tick_d  = first_ch(mask, dir);
          sel_d   = onehot(first_ch(mask, dir));
          busy_d  = 1'b1;
          step_d  = 1'b1;
          cnt_d   = '0;
          dwell_d = dwell;
        end
      end
      RUN: begin
        if (!en || (cnt_q == dwell_q && mask == '0)) begin
          state_d = IDLE;
          sel_d   = '0;
          busy_d  = 1'b0;
        end else if (cnt_q != dwell_q) begin
          cnt_d = cnt_q + 1'b1;
        end else if (nxt_wrap && oneshot) begin
          state_d = IDLE;
          sel_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
`ifdef SEQ_GEN_GAP_EN
          state_d = GAP;
          sel_d   = '0;
          nxt_d   = nxt;
          pwrap_d = nxt_wrap;
`else
          tick_d  = nxt;
          sel_d   = onehot(nxt);
          step_d  = 1'b1;
          wrap_d  = nxt_wrap;
          cnt_d   = '0;
          dwell_d = dwell;
`endif
        end
      end
`ifdef SEQ_GEN_GAP_EN
      GAP: begin
        if (!en) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = RUN;
          tick_d  = nxt_q;
          sel_d   = onehot(nxt_q);
          step_d  = 1'b1;
          wrap_d  = pwrap_q;
          cnt_d   = '0;
          dwell_d = dwell;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        sel_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      sel_q   <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      dwell_q <= '0;
`ifdef SEQ_GEN_GAP_EN
      nxt_q   <= '0;
      pwrap_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      sel_q   <= sel_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
`ifdef SEQ_GEN_GAP_EN
      nxt_q   <= nxt_d;
      pwrap_q <= pwrap_d;
`endif
    end
  end

  assign tick = tick_q;
  assign sel  = sel_q;
  assign step = step_q;
  assign wrap = wrap_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_seq_gen.sv
// Scoreboard bench for seq_gen (8 channels).
// Runs the gap sequences when SEQ_GEN_GAP_EN is defined.
module tb_seq_gen;
  localparam int CH = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst, en, oneshot, start, dir;
  logic [DW-1:0] dwell;
  logic [CH-1:0] mask;
  logic [2:0]    tick;
  logic [CH-1:0] sel;
  logic          step, wrap, done, busy;

  typedef struct packed {
    logic [CH-1:0] sel;
    logic [2:0]    tick;
    logic [3:0]    flg;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_cyc  = 0;

  always #5 clk = ~clk;

  seq_gen #(.CHANNELS(CH), .DWELL_W(DW)) dut (
    .clk(clk), .rst(rst), .en(en), .oneshot(oneshot),
    .start(start), .dir(dir), .dwell(dwell), .mask(mask),
    .tick(tick), .sel(sel), .step(step), .wrap(wrap),
    .done(done), .busy(busy)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // flg = {step, wrap, done, busy}
  task automatic go(input logic [CH-1:0] s, input int t,
                    input logic [3:0] f, input string tag);
    exp_t  e;
    string nm;
    e.sel  = s;
    e.tick = 3'(t);
    e.flg  = f;
    sb.push_back(e);
    @(posedge clk);
    #1;
    n_cyc++;
    nm = $sformatf("%s@%0d", tag, n_cyc);
    check({nm, "_sbq"}, 32'(sb.size()), 32'd1);
    e = sb.pop_front();
    check({nm, "_sel"}, 32'(sel), 32'(e.sel));
    check({nm, "_tick"}, 32'(tick), 32'(e.tick));
    check({nm, "_flags"}, {28'd0, step, wrap, done, busy},
          {28'd0, e.flg});
  endtask

  initial begin
    int ch;
    logic st, wr;
    rst = 1'b1; en = 1'b0; oneshot = 1'b0; start = 1'b0;
    dir = 1'b0; dwell = '0; mask = '0;
    go(8'h00, 0, 4'b0000, "rst");
    go(8'h00, 0, 4'b0000, "rst");
    rst = 1'b0;
    go(8'h00, 0, 4'b0000, "idle");

`ifdef SEQ_GEN_GAP_EN
    mask = 8'h03; en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i % 2 == 0) begin
        ch = (i / 2) % 2;
        wr = (i > 0) && (ch == 0);
        go(8'(1 << ch), ch, {1'b1, wr, 2'b01}, "gap");
      end else begin
        ch = ((i - 1) / 2) % 2;
        go(8'h00, ch, 4'b0001, "gap_hole");
      end
    end
    en = 1'b0;
    go(8'h00, 0, 4'b0000, "gap_off");
    oneshot = 1'b1; start = 1'b1; en = 1'b1;
    go(8'h01, 0, 4'b1001, "gap_os");
    start = 1'b0;
    go(8'h00, 0, 4'b0001, "gap_os_hole");
    go(8'h02, 1, 4'b1001, "gap_os");
    go(8'h00, 1, 4'b0010, "gap_os_done");
    en = 1'b0; oneshot = 1'b0;
`else
    // free-run ascending, dwell 0
    mask = 8'hFF; en = 1'b1;
    for (int i = 0; i < 19; i++) begin
      ch = i % 8;
      wr = (i > 0) && (ch == 0);
      go(8'(1 << ch), ch, {1'b1, wr, 2'b01}, "fr_up");
    end
    en = 1'b0;
    go(8'h00, 2, 4'b0000, "fr_up_off");

    // oneshot sweep over 0x25, dwell 2, stray start mid-sweep
    dwell = 8'd2; mask = 8'h25; oneshot = 1'b1;
    en = 1'b1; start = 1'b1;
    go(8'h01, 0, 4'b1001, "os");
    start = 1'b0;
    go(8'h01, 0, 4'b0001, "os");
    go(8'h01, 0, 4'b0001, "os");
    go(8'h04, 2, 4'b1001, "os");
    start = 1'b1;
    go(8'h04, 2, 4'b0001, "os_start_ign");
    start = 1'b0;
    go(8'h04, 2, 4'b0001, "os");
    go(8'h20, 5, 4'b1001, "os");
    go(8'h20, 5, 4'b0001, "os");
    go(8'h20, 5, 4'b0001, "os");
    go(8'h00, 5, 4'b0010, "os_done");
    go(8'h00, 5, 4'b0000, "os_idle");
    en = 1'b0; oneshot = 1'b0;

    // free-run descending over 0x81, dwell 1
    dir = 1'b1; dwell = 8'd1; mask = 8'h81; en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ch = ((i / 2) % 2 == 0) ? 7 : 0;
      st = (i % 2 == 0);
      wr = st && (i / 2 > 0) && (ch == 7);
      go(8'(1 << ch), ch, {st, wr, 2'b01}, "fr_dn");
    end
    en = 1'b0;
    go(8'h00, 7, 4'b0000, "fr_dn_off");
    dir = 1'b0;

    // mask drops to zero mid-dwell, then a single channel
    mask = 8'hFF; en = 1'b1;
    go(8'h01, 0, 4'b1001, "mk");
    go(8'h01, 0, 4'b0001, "mk");
    go(8'h02, 1, 4'b1001, "mk");
    go(8'h02, 1, 4'b0001, "mk");
    go(8'h04, 2, 4'b1001, "mk");
    mask = 8'h00;
    go(8'h04, 2, 4'b0001, "mk_hold");
    go(8'h00, 2, 4'b0000, "mk_idle");
    mask = 8'h10;
    go(8'h10, 4, 4'b1001, "mk_reent");
    go(8'h10, 4, 4'b0001, "mk_single");
    go(8'h10, 4, 4'b1101, "mk_single_wrap");
    en = 1'b0;
    go(8'h00, 4, 4'b0000, "mk_off");

    // synchronous reset mid-run
    dwell = 8'd0; mask = 8'hFF; en = 1'b1;
    go(8'h01, 0, 4'b1001, "rr");
    go(8'h02, 1, 4'b1001, "rr");
    go(8'h04, 2, 4'b1001, "rr");
    rst = 1'b1;
    go(8'h00, 0, 4'b0000, "rr_rst");
    rst = 1'b0;
    go(8'h01, 0, 4'b1001, "rr_reent");
    go(8'h02, 1, 4'b1001, "rr");
    en = 1'b0;
    go(8'h00, 1, 4'b0000, "rr_off");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_gen.md
Name: seq_gen

Overview:
Parametrised one-hot channel sequencer; successor to the fixed 8-way tick/select sequencer. Steps a one-hot select across CHANNELS outputs and holds each channel for a programmable dwell. Masked channels are skipped. Runs up or down, either free-running or as a single sweep. Drives time-multiplexed enables such as display digit strobes and scan lines.

Parameters:
CHANNELS, 8, number of select outputs (>=2)
DWELL_W, 8, width of dwell count
(derived, not overridable) IDX_W = $clog2(CHANNELS)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset, priority over all inputs
en  in  1  global enable; low forces IDLE
oneshot  in  1  0 = free-run, 1 = single sweep per start
start  in  1  starts a sweep (oneshot=1 only)
dir  in  1  0 = ascending index, 1 = descending
dwell  in  DWELL_W  channel hold time minus 1, in cycles
mask  in  CHANNELS  1 = channel participates
tick  out  IDX_W  current channel index
sel  out  CHANNELS  one-hot select, all zero when idle
step  out  1  1-cycle pulse, same cycle a new channel appears on sel
wrap  out  1  1-cycle pulse when the sequence wraps
done  out  1  1-cycle pulse at end of a oneshot sweep
busy  out  1  high while in RUN

Behaviour:
- All outputs registered. Reset values: tick=0, sel=0, step=0, wrap=0, done=0, busy=0; internal dwell counter=0, state=IDLE.
- FSM states are IDLE and RUN (plus GAP when the optional feature is enabled).
- Entry from IDLE to RUN:
  - Condition: en && mask!=0 && (oneshot ? start : 1).
  - First channel is the first set mask bit searching from index 0 (dir=0) or CHANNELS-1 (dir=1).
  - Next cycle: sel=onehot(first), tick=first, busy=1, step=1. Latency is 1 cycle.
- In RUN:
  - Dwell counter counts 0..dwell. The channel is held dwell+1 cycles; dwell is sampled when a channel is entered.
  - On expiry, advance to the next set mask bit in direction dir, wrapping modulo CHANNELS.
  - mask and dir are sampled at the advance. Changes mid-dwell do not cut the current channel short.
- wrap asserts with the new sel when the index wraps: new index <= old index for dir=0, >= old for dir=1.
  - A single enabled channel re-selects itself and pulses step and wrap on every expiry.
- Oneshot: the sweep covers each enabled channel once, in direction order.
  - Instead of wrapping, go to IDLE: sel=0, busy=0, done=1 in the same cycle. No wrap pulse.
  - start is ignored while in RUN.
- Free-run: continues indefinitely while en is high. start is ignored.
- en low in RUN: next cycle IDLE, sel=0, busy=0, tick holds, no done pulse.
- mask==0 at an advance: go to IDLE as for en low. Free-run re-enters RUN automatically once mask!=0.
- Changing oneshot mid-run takes effect at the next wrap decision.
- rst mid-run: next cycle all outputs at reset values. With en still high, re-entry occurs the cycle after rst is released.
- Invariants:
  - sel is always one-hot or zero.
  - Whenever busy=1, sel==onehot(tick).
  - A masked channel is never selected at entry or advance.

Optional Feature:
SEQ_GEN_GAP_EN: break-before-make.
- When defined: every advance first passes through the GAP state for exactly 1 cycle. During GAP, sel=0, tick holds the old value, busy=1. The next channel and the step/wrap pulses appear the following cycle.
  - Per-channel period becomes dwell+2 cycles.
  - A oneshot end goes directly to IDLE without a GAP cycle.
- When undefined: no GAP state; sel switches directly between channels.

Test Plan:
- CHANNELS=8, free-run, dir=0, dwell=0, mask=FF, en=1 -> sel 01,02,04,...,80,01 on consecutive cycles; step every cycle; wrap only with each 80->01.
- Oneshot, dwell=2, mask=8'h25, start pulse -> sel=01 x3, 04 x3, 20 x3, then 00; busy high 9 cycles; done pulse coincident with sel->00; a second start during the sweep is ignored.
- Free-run, dir=1, dwell=1, mask=8'h81 -> sel 80,80,01,01,80,...; wrap pulses with each 01->80 transition.
- Free-run, mask changed 8'hFF->8'h00 while sel=04 mid-dwell -> 04 completes its dwell, then sel=00 and busy=0; restoring mask=8'h10 -> sel=10 one cycle later.
- Free-run, rst asserted 1 cycle while sel=04 -> next cycle sel=00, tick=0, busy=0; cycle after release, sel=01 with step=1.
- With SEQ_GEN_GAP_EN, dwell=0, mask=8'h03, free-run -> sel 01,00,02,00,01,...; tick holds during 00 cycles; wrap with each 02->01 transition.
